// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with runtime framing, sticky error flags and a one-deep holding register
// Ports:
//   clk, reset_n                  clock and asynchronous active-low reset
//   baud_tick                     one-clk oversample enable (OVS ticks per bit)
//   rx                            asynchronous serial line, idle high
//   data_len, parity_en,          frame configuration, latched when a start bit is seen
//   parity_mode, stop2
//   read_ack, clear_err           one-clk consumer pulses
//   rx_data, rx_valid             holding register toward the consumer
//   char_done                     one-clk pulse per completed frame, error and break frames included
//   parity_err, framing_err,      sticky status, cleared by clear_err
//   overflow, break_det
//   rx_busy                       receiver not idle
// Define RX_TIMEOUT_EN to add rx_timeout: set after TIMEOUT_CHARS idle character times with unread data.
module uart_rx_param #(
  parameter int DATA_W = 8,
  parameter int OVS = 16
`ifdef RX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CHARS = 4
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              baud_tick,
  input  logic              rx,
  input  logic [3:0]        data_len,
  input  logic              parity_en,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              read_ack,
  input  logic              clear_err,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              char_done,
  output logic              parity_err,
  output logic              framing_err,
  output logic              overflow,
  output logic              break_det,
  output logic              rx_busy
`ifdef RX_TIMEOUT_EN
  ,
  output logic              rx_timeout
`endif
);
  localparam int SW = $clog2(OVS);
  localparam logic [3:0] MAXLEN = 4'(DATA_W);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, BRKWAIT} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [2:0] vote;
  logic [SW-1:0] scnt;
  logic [3:0] len, bcnt;
  logic [1:0] pmode;
  logic [DATA_W-1:0] shreg;
  logic filt, mid, last, start_det, finish, brk, exp_par, ok_done, load;
  logic pen, st2, perr, ferr, all_zero, done_brk;
  assign filt = (vote[0] & vote[1]) | (vote[0] & vote[2]) | (vote[1] & vote[2]);
  assign mid = scnt == SW'(OVS / 2 - 1);
  assign last = scnt == SW'(OVS - 1);
  assign start_det = baud_tick && state == IDLE && !filt;
  // a break is a frame whose every sampled bit, including the final stop sample, was 0
  assign brk = all_zero && !filt;
  assign exp_par = pmode[1] ? ~pmode[0] : ^shreg ^ pmode[0];
  assign rx_busy = state != IDLE;
  // frame results are committed in the char_done clk so a same-clk read_ack can make room
  assign ok_done = char_done && !done_brk;
  assign load = ok_done && (!rx_valid || read_ack);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    finish = 1'b0;
    if (baud_tick)
      case (state)
        IDLE: state_n = filt ? IDLE : START;
        START: state_n = !mid ? START : filt ? IDLE : DATA;
        DATA: state_n = (last && bcnt == len - 4'd1) ? (pen ? PARITY : STOP1) : DATA;
        PARITY: state_n = last ? STOP1 : PARITY;
        STOP1: begin
          finish = last && !st2;
          state_n = !last ? STOP1 : st2 ? STOP2 : brk ? BRKWAIT : IDLE;
        end
        STOP2: begin
          finish = last;
          state_n = !last ? STOP2 : brk ? BRKWAIT : IDLE;
        end
        BRKWAIT: state_n = filt ? IDLE : BRKWAIT;
        default: state_n = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= 2'b11;
      vote <= 3'b111;
      scnt <= '0;
      bcnt <= '0;
      len <= '0;
      pen <= 1'b0;
      pmode <= 2'b00;
      st2 <= 1'b0;
      shreg <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
      all_zero <= 1'b0;
      char_done <= 1'b0;
      done_brk <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      char_done <= finish;
      done_brk <= finish && brk;
      if (baud_tick) begin
        vote <= {vote[1:0], sync[1]};
        // restart at mid start bit so every later sample lands mid-bit
        scnt <= (state == IDLE || state == BRKWAIT || (state == START && mid) || last) ? '0 : scnt + SW'(1);
        if (start_det) begin
          len <= (data_len < 4'd5 || data_len > MAXLEN) ? MAXLEN : data_len;
          pen <= parity_en;
          pmode <= parity_mode;
          st2 <= stop2;
          shreg <= '0;
          bcnt <= '0;
          perr <= 1'b0;
          ferr <= 1'b0;
          all_zero <= 1'b1;
        end
        if (last) begin
          if (state == DATA) begin
            shreg <= shreg | (DATA_W'(filt) << bcnt);
            bcnt <= bcnt + 4'd1;
          end
          if (state == PARITY && filt != exp_par) perr <= 1'b1;
          if ((state == STOP1 || state == STOP2) && !filt) ferr <= 1'b1;
          if (state inside {DATA, PARITY, STOP1, STOP2} && filt) all_zero <= 1'b0;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
      parity_err <= 1'b0;
      framing_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      if (load) rx_data <= shreg;
      rx_valid <= load || (rx_valid && !read_ack);
      overflow <= (ok_done && rx_valid && !read_ack) || (overflow && !clear_err);
      parity_err <= (ok_done && perr) || (parity_err && !clear_err);
      framing_err <= (ok_done && ferr) || (framing_err && !clear_err);
      break_det <= done_brk || (break_det && !clear_err);
    end
  end
`ifdef RX_TIMEOUT_EN
  localparam int TO_LIMIT = TIMEOUT_CHARS * (DATA_W + 3) * OVS;
  localparam int TW = $clog2(TO_LIMIT + 1);
  logic [TW-1:0] idle_cnt;
  logic idle_tick;
  assign idle_tick = baud_tick && state == IDLE && rx_valid;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      rx_timeout <= 1'b0;
    end else begin
      idle_cnt <= (start_det || read_ack) ? '0 : (idle_tick && idle_cnt != TW'(TO_LIMIT)) ? idle_cnt + TW'(1) : idle_cnt;
      rx_timeout <= (idle_tick && idle_cnt == TW'(TO_LIMIT - 1)) || (rx_timeout && !read_ack && !clear_err);
    end
  end
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed table-driven bench for uart_rx_param (DATA_W=8, OVS=16, baud_tick every clk)
module tb_uart_rx_param;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic baud_tick = 1'b1;
  logic rx = 1'b1;
  logic [3:0] data_len = 4'd8;
  logic parity_en = 1'b0;
  logic [1:0] parity_mode = 2'b00;
  logic stop2 = 1'b0;
  logic read_ack = 1'b0;
  logic clear_err = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, char_done, parity_err, framing_err, overflow, break_det, rx_busy;
`ifdef RX_TIMEOUT_EN
  logic rx_timeout;
`endif
  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;
  typedef struct {
    logic [8:0] d;
    logic [3:0] len_cfg;
    int n;
    logic pen;
    logic [1:0] pm;
    logic pb;
    logic st2;
    logic [1:0] sv;
    logic [2:0] ctl;
    logic [7:0] e_data;
    logic e_valid;
    logic [3:0] e_flg;
  } vec_t;
  uart_rx_param #(.DATA_W(8), .OVS(16)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .baud_tick(baud_tick),
    .rx(rx),
    .data_len(data_len),
    .parity_en(parity_en),
    .parity_mode(parity_mode),
    .stop2(stop2),
    .read_ack(read_ack),
    .clear_err(clear_err),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .char_done(char_done),
    .parity_err(parity_err),
    .framing_err(framing_err),
    .overflow(overflow),
    .break_det(break_det),
    .rx_busy(rx_busy)
`ifdef RX_TIMEOUT_EN
    ,
    .rx_timeout(rx_timeout)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (char_done) n_done++;
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic pulse_ack();
    @(negedge clk) read_ack = 1'b1;
    @(negedge clk) read_ack = 1'b0;
  endtask
  task automatic pulse_clr();
    @(negedge clk) clear_err = 1'b1;
    @(negedge clk) clear_err = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // drives start, data LSB first, optional parity, stop bits, then three idle bit times;
  // with ack_done set, read_ack is raised in the clk where char_done is high
  task automatic send_frame(input logic [8:0] d, input int n, input logic pen, input logic pb,
                            input int ns, input logic [1:0] sv, input logic ack_done);
    logic [15:0] f;
    int nb;
    f = '1;
    f[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < n; i++) begin
      f[nb] = d[i];
      nb++;
    end
    if (pen) begin
      f[nb] = pb;
      nb++;
    end
    for (int i = 0; i < ns; i++) begin
      f[nb] = sv[i];
      nb++;
    end
    for (int b = 0; b < nb + 3; b++)
      for (int c = 0; c < 16; c++) begin
        @(negedge clk);
        rx = f[b];
        read_ack = ack_done && char_done;
      end
    read_ack = 1'b0;
  endtask
  initial begin
    vec_t vt[15];
    int d0;
    // d, len_cfg, n, pen, pm, pb, st2, sv{2nd,1st}, ctl{clr,ack,ack_on_done}, e_data, e_valid, e_flg{perr,ferr,ovf,brk}
    vt[0]  = '{9'h0A5, 4'd8, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 3'b000, 8'hA5, 1'b1, 4'b0000};
    vt[1]  = '{9'h041, 4'd7, 7, 1'b1, 2'b01, 1'b1, 1'b0, 2'b11, 3'b010, 8'h41, 1'b1, 4'b0000};
    vt[2]  = '{9'h041, 4'd7, 7, 1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 3'b010, 8'h41, 1'b1, 4'b1000};
    vt[3]  = '{9'h055, 4'd8, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b10, 3'b110, 8'h55, 1'b1, 4'b0100};
    vt[4]  = '{9'h000, 4'd8, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 3'b100, 8'h55, 1'b1, 4'b0001};
    vt[5]  = '{9'h011, 4'd8, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 3'b110, 8'h11, 1'b1, 4'b0000};
    vt[6]  = '{9'h022, 4'd8, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 3'b000, 8'h11, 1'b1, 4'b0010};
    vt[7]  = '{9'h033, 4'd8, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 3'b001, 8'h33, 1'b1, 4'b0010};
    vt[8]  = '{9'h01B, 4'd5, 5, 1'b1, 2'b00, 1'b0, 1'b1, 2'b11, 3'b110, 8'h1B, 1'b1, 4'b0000};
    vt[9]  = '{9'h080, 4'd8, 8, 1'b1, 2'b10, 1'b0, 1'b0, 2'b11, 3'b110, 8'h80, 1'b1, 4'b1000};
    vt[10] = '{9'h0C3, 4'd3, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 3'b110, 8'hC3, 1'b1, 4'b0000};
    vt[11] = '{9'h05A, 4'd8, 8, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01, 3'b110, 8'h5A, 1'b1, 4'b0100};
    vt[12] = '{9'h02A, 4'd6, 6, 1'b1, 2'b11, 1'b0, 1'b0, 2'b11, 3'b110, 8'h2A, 1'b1, 4'b0000};
    vt[13] = '{9'h02A, 4'd6, 6, 1'b1, 2'b11, 1'b1, 1'b0, 2'b11, 3'b110, 8'h2A, 1'b1, 4'b1000};
    vt[14] = '{9'h0E7, 4'd12, 8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 3'b110, 8'hE7, 1'b1, 4'b0000};
    idle(3);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset char_done", char_done, 0);
    chk("reset flags", {parity_err, framing_err, overflow, break_det}, 0);
    chk("reset rx_busy", rx_busy, 0);
`ifdef RX_TIMEOUT_EN
    chk("reset rx_timeout", rx_timeout, 0);
`endif
    reset_n = 1'b1;
    idle(40);
    chk("idle rx_busy", rx_busy, 0);
    chk("idle rx_valid", rx_valid, 0);
    for (int i = 0; i < 15; i++) begin
      data_len = vt[i].len_cfg;
      parity_en = vt[i].pen;
      parity_mode = vt[i].pm;
      stop2 = vt[i].st2;
      if (vt[i].ctl[2]) pulse_clr();
      if (vt[i].ctl[1]) pulse_ack();
      d0 = n_done;
      send_frame(vt[i].d, vt[i].n, vt[i].pen, vt[i].pb, vt[i].st2 ? 2 : 1, vt[i].sv, vt[i].ctl[0]);
      chk($sformatf("v%0d rx_data", i), rx_data, vt[i].e_data);
      chk($sformatf("v%0d rx_valid", i), rx_valid, vt[i].e_valid);
      chk($sformatf("v%0d parity_err", i), parity_err, vt[i].e_flg[3]);
      chk($sformatf("v%0d framing_err", i), framing_err, vt[i].e_flg[2]);
      chk($sformatf("v%0d overflow", i), overflow, vt[i].e_flg[1]);
      chk($sformatf("v%0d break_det", i), break_det, vt[i].e_flg[0]);
      chk($sformatf("v%0d char_done pulses", i), n_done - d0, 1);
      chk($sformatf("v%0d rx_busy", i), rx_busy, 0);
    end
    pulse_ack();
    chk("ack rx_valid", rx_valid, 0);
    chk("ack rx_data held", rx_data, 8'hE7);
    data_len = 4'd8;
    parity_en = 1'b0;
    stop2 = 1'b0;
    pulse_clr();
    d0 = n_done;
    for (int c = 0; c < 10 * 16 + 64; c++) @(negedge clk) rx = 1'b0;
    chk("brkwait rx_busy", rx_busy, 1);
    chk("brkwait break_det", break_det, 1);
    chk("brkwait char_done pulses", n_done - d0, 1);
    chk("brkwait rx_valid", rx_valid, 0);
    @(negedge clk) rx = 1'b1;
    idle(48);
    chk("brk release rx_busy", rx_busy, 0);
    pulse_clr();
    chk("clear break_det", break_det, 0);
    d0 = n_done;
    repeat (4) @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    idle(3);
    chk("glitch start rx_busy", rx_busy, 1);
    idle(60);
    chk("glitch rx_busy", rx_busy, 0);
    chk("glitch char_done pulses", n_done - d0, 0);
    chk("glitch flags", {parity_err, framing_err, overflow, break_det}, 0);
    chk("glitch rx_valid", rx_valid, 0);
    send_frame(9'h096, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    chk("pre-reset rx_data", rx_data, 8'h96);
    chk("pre-reset rx_valid", rx_valid, 1);
    for (int c = 0; c < 40; c++) @(negedge clk) rx = 1'b0;
    chk("mid-data rx_busy", rx_busy, 1);
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("async reset rx_data", rx_data, 0);
    chk("async reset rx_valid", rx_valid, 0);
    chk("async reset rx_busy", rx_busy, 0);
    chk("async reset char_done", char_done, 0);
    rx = 1'b1;
    idle(5);
    reset_n = 1'b1;
    d0 = n_done;
    idle(200);
    chk("post-reset char_done pulses", n_done - d0, 0);
    chk("post-reset rx_valid", rx_valid, 0);
`ifdef RX_TIMEOUT_EN
    send_frame(9'h07E, 8, 1'b0, 1'b0, 1, 2'b11, 1'b0);
    chk("timeout rx_data", rx_data, 8'h7E);
    idle(600);
    chk("timeout early", rx_timeout, 0);
    idle(120);
    chk("timeout set", rx_timeout, 1);
    pulse_ack();
    chk("timeout cleared", rx_timeout, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
